// File: rtl/serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub_pkg
// Brief    : Shared FSM state type and default width for serial_addsub_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package serial_addsub_pkg;

  localparam int unsigned c_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_addsub_ctrl_full_adder.sv
`default_nettype none
// ============================================================================
// Module   : full_adder
// Brief    : One-bit full-adder cell; the whole datapath of the serial unit.
// Revision : 1.0 - initial release
// ============================================================================
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule
`default_nettype wire

// File: rtl/serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub_ctrl
// Brief    : Bit-serial (LSB first) add/subtract unit, one full adder, WIDTH
//            cycles per operation. Optional SERIAL_ADDSUB_OVF_EN builds the
//            signed overflow flag; otherwise ovf_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int             CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]  c_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_done;
  logic             w_accept;
  logic             w_s;
  logic             w_c;

  // The done_o cycle still counts as busy, so a start there is also ignored.
  assign w_accept = (r_state == IDLE) && start_i && !r_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (r_cnt == c_LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  full_adder u_fa (
    .a_i (r_a[0]),
    .b_i (r_b[0]),
    .c_i (r_carry),
    .s_o (w_s),
    .c_o (w_c)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a_i;
      r_b     <= sub_i ? ~b_i : b_i;
      r_carry <= sub_i;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_res   <= {w_s, r_res[WIDTH-1:1]};
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_c;
      if (r_cnt != c_LAST) r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_sum  <= r_res;
        r_cout <= r_carry;
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic r_ovf_bit;
  logic r_ovf;

  // Carry into the MSB is r_carry during the final bit-cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovf_bit <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (r_state == RUN && r_cnt == c_LAST) r_ovf_bit <= r_carry ^ w_c;
      if (r_state == DONE) r_ovf <= r_ovf_bit;
    end
  end

  assign ovf_o = r_ovf;
`else
  assign ovf_o = 1'b0;
`endif

  assign busy_o = (r_state != IDLE) || r_done;
  assign done_o = r_done;
  assign sum_o  = r_sum;
  assign cout_o = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_addsub_ctrl
// Brief    : Self-checking bench for serial_addsub_ctrl (WIDTH=8): vector
//            table, scoreboard queue, held-start and mid-run reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int           n_total = 0;
  int           n_bad   = 0;
  int           n_done  = 0;
  int           n_push  = 0;
  exp_t         sb[$];
  logic [W-1:0] prev_sum = '0;
  vec_t         tbl[9];

  always #5 clk = ~clk;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .sub_i   (sub),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
    .cout_o  (cout),
    .ovf_o   (ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Signed overflow from operand signs: only meaningful when the flag is built.
  function automatic logic ovf_model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] yb;
    logic [W-1:0] r;
    yb = s ? ~y : y;
    r  = x + yb + {{(W-1){1'b0}}, s};
`ifdef SERIAL_ADDSUB_OVF_EN
    return (x[W-1] == yb[W-1]) && (r[W-1] != x[W-1]);
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sum", {24'd0, sum}, {24'd0, e.sum});
        chk("cout", {31'd0, cout}, {31'd0, e.cout});
        chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        prev_sum = e.sum;
      end
    end
  end

  task automatic do_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] es, input logic ec, input logic hold);
    int n;
    @(negedge clk);
    start = 1'b1; sub = s; a = x; b = y;
    sb.push_back('{sum: es, cout: ec, ovf: ovf_model(s, x, y)});
    n_push++;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      sub = ~s; a = 8'h11; b = 8'h22;
    end else begin
      start = 1'b0;
    end
    chk("busy_rise", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 40) begin
      if (n == 2) chk("hold_prev", {24'd0, sum}, {24'd0, prev_sum});
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("latency", n, W + 1);
    chk("busy_at_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    chk("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 8'd5,   8'd3, 8'd8,   1'b0};
    tbl[1] = '{1'b0, 8'd200, 8'd100, 8'd44, 1'b1};
    tbl[2] = '{1'b1, 8'd5,   8'd3, 8'd2,   1'b1};
    tbl[3] = '{1'b1, 8'd3,   8'd5, 8'hFE,  1'b0};
    tbl[4] = '{1'b0, 8'd127, 8'd1, 8'd128, 1'b0};
    tbl[5] = '{1'b0, 8'd255, 8'd1, 8'd0,   1'b1};
    tbl[6] = '{1'b1, 8'd0,   8'd0, 8'd0,   1'b1};
    tbl[7] = '{1'b1, 8'd128, 8'd1, 8'd127, 1'b1};
    tbl[8] = '{1'b0, 8'd0,   8'd0, 8'd0,   1'b0};

    repeat (2) @(negedge clk);
    chk("rst_outputs", {20'd0, busy, done, sum, cout, ovf}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].sum, tbl[i].cout, 1'b0);
    end

    // start held through RUN/DONE with other operands: one result, first operands
    do_op(1'b0, 8'd20, 8'd22, 8'd42, 1'b0, 1'b1);
    repeat (12) @(negedge clk);
    chk("held_no_requeue", {31'd0, busy}, 32'd0);

    // reset in the middle of RUN aborts without a done pulse
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'd9; b = 8'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst", {20'd0, busy, done, sum, cout, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_sum = '0;
    repeat (12) @(negedge clk);
    chk("no_done_after_abort", {31'd0, busy}, 32'd0);
    do_op(1'b0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("done_count", n_done, n_push);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
